// File: rtl/melody_pkg.sv
// Shared types and helpers for the melody sequencer: FSM state, score entry layout,
// rest marker and note-duration arithmetic.
package melody_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTbl,
        StFetch,
        StPlay,
        StGap,
        StDone
    } seq_state_t;

    typedef struct packed {
        logic [2:0] dur;
        logic [4:0] idx;
    } score_entry_t;

    localparam logic [4:0] REST_IDX = 5'd31;

    // Duration code d stretches the shortest note by 2^d.
    function automatic int unsigned dur_cycles(input int unsigned unit, input logic [2:0] d);
        return unit << d;
    endfunction

endpackage

// File: rtl/score_buffer.sv
// Score storage: Depth x 8-bit register array with one write port and a registered read port.
module score_buffer #(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [Depth];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a stored score of (duration, note) entries, timing notes and gaps from the tempo.
// Define MELODY_LOOP_EN to let the loop input wrap playback back to entry 0.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned CLK_REF     = 50_000_000,
    parameter int unsigned TEMP        = 8,
    parameter int unsigned NOTE_UNIT   = CLK_REF / TEMP,
    parameter int unsigned GAP_CYCLES  = NOTE_UNIT / 8,
    parameter int unsigned NUM_OCTAV   = 1,
    parameter int unsigned SCORE_DEPTH = 16,
    localparam int unsigned NumNotes   = NUM_OCTAV * 7,
    localparam int unsigned AddrW      = $clog2(NumNotes),
    localparam int unsigned StepW      = $clog2(SCORE_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             enable_l,
    input  logic             score_we,
    input  logic [7:0]       score_wdata,
    input  logic             score_clr,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic             table_work,
    output logic [AddrW-1:0] note_addr,
    output logic             note_play,
    output logic             busy,
    output logic             done,
    output logic             score_full,
    output logic [StepW-1:0] step
);

    localparam int unsigned PtrW = StepW + 1;
    localparam int unsigned CntW = $clog2(NOTE_UNIT * 128);

    seq_state_t       state_q, state_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [StepW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [AddrW-1:0] note_addr_q, note_addr_d;
    logic             sound_q, sound_d;
    logic             buf_we;
    logic             advance;
    logic             last_entry;
    logic             loop_en;
    logic [7:0]       rd_data;
    score_entry_t     entry;

`ifdef MELODY_LOOP_EN
    assign loop_en = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_en     = 1'b0;
`endif

    // Read address is the next-state pointer so the entry is ready during FETCH.
    score_buffer #(
        .Depth (SCORE_DEPTH)
    ) u_score_buffer (
        .clk_i   (clk),
        .rst_ni  (reset_l),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q[StepW-1:0]),
        .wdata_i (score_wdata),
        .raddr_i (rd_ptr_d),
        .rdata_o (rd_data)
    );

    assign entry      = score_entry_t'(rd_data);
    assign score_full = (wr_ptr_q == PtrW'(SCORE_DEPTH));
    assign last_entry = (PtrW'(rd_ptr_q) + PtrW'(1)) >= wr_ptr_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        note_addr_d = note_addr_q;
        sound_d     = sound_q;
        buf_we      = 1'b0;
        advance     = 1'b0;

        if (stop) begin
            state_d  = StIdle;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else if (!enable_l) begin
            case (state_q)
                StIdle: begin
                    rd_ptr_d = '0;
                    if (score_clr) begin
                        wr_ptr_d = '0;
                    end else if (score_we && !score_full) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                    end
                    if (start) begin
                        state_d = (wr_ptr_q != '0) ? StWaitTbl : StDone;
                    end
                end
                StWaitTbl: begin
                    if (table_work) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    // Rests and notes beyond the table keep the previous address and play silent.
                    if (entry.idx != REST_IDX && 32'(entry.idx) < NumNotes) begin
                        note_addr_d = AddrW'(entry.idx);
                        sound_d     = 1'b1;
                    end else begin
                        sound_d     = 1'b0;
                    end
                    cnt_d   = CntW'(dur_cycles(NOTE_UNIT, entry.dur) - 1);
                    state_d = StPlay;
                end
                StPlay: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        cnt_d   = CntW'(GAP_CYCLES - 1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (advance) begin
                if (!last_entry) begin
                    state_d  = StFetch;
                    rd_ptr_d = rd_ptr_q + StepW'(1);
                end else if (loop_en) begin
                    state_d  = StFetch;
                    rd_ptr_d = '0;
                end else begin
                    state_d  = StDone;
                    rd_ptr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            note_addr_q <= '0;
            sound_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            note_addr_q <= note_addr_d;
            sound_q     <= sound_d;
        end
    end

    assign note_addr = note_addr_q;
    assign note_play = (state_q == StPlay) && sound_q && table_work && !enable_l && !stop;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign step      = rd_ptr_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scenarios plus randomized scores, each
// compared cycle by cycle against a timeline expanded from the score.
module tb_melody_sequencer;

    localparam int NU    = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;
    localparam int NOTES = 7;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       enable_l = 1'b0;
    logic       score_we = 1'b0;
    logic [7:0] score_wdata = 8'h00;
    logic       score_clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic       table_work = 1'b0;
    logic [2:0] note_addr;
    logic       note_play;
    logic       busy;
    logic       done;
    logic       score_full;
    logic [1:0] step;

    always #5 clk = ~clk;

    melody_sequencer #(
        .NOTE_UNIT   (NU),
        .GAP_CYCLES  (GAP),
        .NUM_OCTAV   (1),
        .SCORE_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .enable_l    (enable_l),
        .score_we    (score_we),
        .score_wdata (score_wdata),
        .score_clr   (score_clr),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .table_work  (table_work),
        .note_addr   (note_addr),
        .note_play   (note_play),
        .busy        (busy),
        .done        (done),
        .score_full  (score_full),
        .step        (step)
    );

    typedef struct {
        bit play;
        int addr;
        int step;
        bit busy;
        bit done;
        bit wt;
    } exp_t;

    exp_t       sched[$];
    logic [7:0] score_q[$];
    int         model_addr = 0;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t rec(bit play, int addr, int stp, bit bsy, bit dn, bit wt);
        exp_t r;
        r.play = play;
        r.addr = addr;
        r.step = stp;
        r.busy = bsy;
        r.done = dn;
        r.wt   = wt;
        return r;
    endfunction

    // Timeline after the start edge: wait-for-table, then per entry fetch/play/gap, done, idle.
    function automatic void build_sched();
        int a;
        a = model_addr;
        sched.delete();
        if (score_q.size() != 0) begin
            sched.push_back(rec(0, a, 0, 1, 0, 1));
            foreach (score_q[k]) begin
                int d;
                int idx;
                bit snd;
                d   = int'(score_q[k][7:5]);
                idx = int'(score_q[k][4:0]);
                snd = (idx < NOTES);
                sched.push_back(rec(0, a, k, 1, 0, 0));
                if (snd) a = idx;
                for (int c = 0; c < (NU << d); c++) sched.push_back(rec(snd, a, k, 1, 0, 0));
                for (int c = 0; c < GAP; c++) sched.push_back(rec(0, a, k, 1, 0, 0));
            end
        end
        sched.push_back(rec(0, a, 0, 0, 1, 0));
        sched.push_back(rec(0, a, 0, 0, 0, 0));
    endfunction

    function automatic logic [7:0] rand_entry();
        logic [2:0] d;
        logic [4:0] idx;
        int         r;
        d = 3'($urandom_range(0, 2));
        r = $urandom_range(0, 7);
        if (r == 0) idx = 5'd31;
        else if (r == 1) idx = 5'($urandom_range(7, 30));
        else idx = 5'($urandom_range(0, 6));
        return {d, idx};
    endfunction

    // Clear (with a simultaneous write that must lose), then write entries back to back.
    task automatic load(input logic [7:0] ents[$]);
        @(negedge clk);
        score_clr   = 1'b1;
        score_we    = 1'b1;
        score_wdata = 8'hff;
        @(negedge clk);
        score_clr = 1'b0;
        score_we  = 1'b0;
        #1;
        chk("clr_full", score_full, 0);
        score_q.delete();
        foreach (ents[i]) begin
            score_we    = 1'b1;
            score_wdata = ents[i];
            @(negedge clk);
            if (score_q.size() < DEPTH) score_q.push_back(ents[i]);
            #1;
            chk("score_full", score_full, score_q.size() == DEPTH);
        end
        score_we = 1'b0;
    endtask

    task automatic play_run(input int stop_at, input bit freeze, input bit rnd_tw, input int tw_hold);
        int   cur;
        bit   adv;
        exp_t e;
        cur = 0;
        build_sched();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && cur < sched.size(); cyc++) begin
            e        = sched[cur];
            enable_l = freeze && !e.done && ($urandom_range(0, 5) == 0);
            if (cyc < tw_hold) table_work = 1'b0;
            else if (rnd_tw) table_work = ($urandom_range(0, 3) != 0);
            else table_work = 1'b1;
            stop = (cyc == stop_at);
`ifndef MELODY_LOOP_EN
            loop = 1'($urandom_range(0, 1));
`endif
            #1;
            chk("note_play", note_play, e.play && table_work && !enable_l && !stop);
            chk("note_addr", note_addr, e.addr);
            chk("step", step, e.step);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            adv = !enable_l && (!e.wt || table_work);
            if (stop) begin
                @(negedge clk);
                stop       = 1'b0;
                enable_l   = 1'b0;
                table_work = 1'b1;
                #1;
                chk("stop_busy", busy, 0);
                chk("stop_no_done", done, 0);
                chk("stop_step", step, 0);
                chk("stop_play", note_play, 0);
                model_addr = e.addr;
                return;
            end
            @(negedge clk);
            if (adv) cur++;
        end
        enable_l   = 1'b0;
        table_work = 1'b1;
        chk("run_bound", cur, sched.size());
        model_addr = sched[sched.size()-1].addr;
    endtask

    initial begin
        logic [7:0] ents[$];
        int         seen;

        #12;
        chk("rst_note_addr", note_addr, 0);
        chk("rst_note_play", note_play, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", score_full, 0);
        chk("rst_step", step, 0);
        @(negedge clk);
        reset_l    = 1'b1;
        table_work = 1'b1;

        ents = '{8'h02, 8'h25};
        load(ents);
        play_run(-1, 0, 0, 0);

        ents = '{8'h1f, 8'h23};
        load(ents);
        play_run(-1, 0, 0, 0);
        play_run(-1, 0, 0, 10);
        play_run(-1, 1, 0, 0);
        play_run(4, 0, 0, 0);

        ents = '{8'h01, 8'h22, 8'h43, 8'h04, 8'h06};
        load(ents);
        play_run(-1, 0, 0, 0);

        ents.delete();
        load(ents);
        play_run(-1, 0, 0, 0);

        // Asynchronous reset in the middle of a note.
        ents = '{8'h24, 8'h21};
        load(ents);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_l = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_play", note_play, 0);
        chk("arst_addr", note_addr, 0);
        chk("arst_step", step, 0);
        @(negedge clk);
        reset_l    = 1'b1;
        model_addr = 0;
        score_q.delete();

        repeat (25) begin
            int n;
            int stop_at;
            n = $urandom_range(1, 4);
            ents.delete();
            for (int i = 0; i < n; i++) ents.push_back(rand_entry());
            load(ents);
            stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            play_run(stop_at, 1, 1, 0);
        end

`ifdef MELODY_LOOP_EN
        ents = '{8'h01, 8'h03};
        load(ents);
        loop = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 42; c++) begin
            #1;
            if (c >= 1) chk("loop_step", step, (((c - 1) % 14) < 7) ? 0 : 1);
            chk("loop_no_done", done, 0);
            chk("loop_busy", busy, 1);
            @(negedge clk);
        end
        loop = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            #1;
            if (done === 1'b1) seen = 1;
            @(negedge clk);
        end
        chk("loop_end_done", seen, 1);
        @(negedge clk);
        model_addr = 3;
`else
        seen = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
